serial_add_ctrl: RTL

Bit-serial adder sequencer. It adds two N-bit operands with a single 1-bit full-adder cell, processing one bit per clock, LSB first, with a registered carry between bits. It gives small-area designs a start/done handshake in front of the adder cell, so one cell serves any operand width.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_ctrl_if.sv | 14 +
 rtl/fa_cell.sv | 11 +
 rtl/serial_add_ctrl.sv | 77 +++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder
package serial_add_pkg;
    localparam int DEF_N = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        ADD  = S_ADD,
        DONE = S_DONE
    } state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/done handshake, operands and result of the serial adder
interface serial_add_ctrl_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/fa_cell.sv
// fa_cell: combinational 1-bit full adder
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (b & c) | (a & c);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two N-bit operands LSB first through a single full-adder cell
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int CW = 4
) (
    input logic clk,
    input logic reset,
    serial_add_ctrl_if.slave bus
);
    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  r_sh;
    logic [N-1:0]  sum_q;
    logic          carry;
    logic          cout_q;
    logic          ovf_q;
    logic [CW-1:0] idx;
    logic          s_bit;
    logic          c_bit;

    fa_cell u_fa (
        .a(a_sh[0]),
        .b(b_sh[0]),
        .c(carry),
        .sum(s_bit),
        .carry(c_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_sh  <= bus.a;
                    b_sh  <= bus.b;
                    carry <= bus.cin;
                    r_sh  <= '0;
                    idx   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    r_sh  <= {s_bit, r_sh[N-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_bit;
                    idx   <= idx + 1'b1;
                    // MSB step: carry holds carry-into bit N-1, c_bit is carry-out
                    if (idx == CW'(N - 1)) begin
                        sum_q  <= {s_bit, r_sh[N-1:1]};
                        cout_q <= c_bit;
                        ovf_q  <= carry ^ c_bit;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
